// File: rtl/audio_sched_pkg.sv
// Package: audio_sched_pkg
// Purpose: shared types and constants for the audio playback scheduler slice.
//   sched_state_t : scheduler FSM states (IDLE, STREAM, DRAIN)
//   word_len_t    : serializer word-length encoding (16/20/24/32 bit)
//   FRAME_W       : stereo frame width, {L[63:32], R[31:0]}
package audio_sched_pkg;

  localparam int FRAME_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } sched_state_t;

  typedef enum logic [1:0] {
    WL16,
    WL20,
    WL24,
    WL32
  } word_len_t;

endpackage

// File: rtl/audio_playback_scheduler_if.sv
// Interface: audio_playback_scheduler_if
// Purpose: bundles the producer-side handshake of the playback scheduler.
// Signals (NUM_SRC producers, one bit / one 64-bit slice per producer):
//   src_req   : producer i wants the serializer (held for the whole stream)
//   src_valid : producer i frame valid
//   src_data  : producer i frame, slice [64*i +: 64]
//   src_ready : frame accepted when src_valid[i] & src_ready[i]
//   src_grant : one-hot current owner, 0 when none
// Modports: master = producer side, slave = scheduler side.
interface audio_playback_scheduler_if
  import audio_sched_pkg::*;
#(
  parameter int NUM_SRC = 4
) ();

  logic [NUM_SRC-1:0]         src_req;
  logic [NUM_SRC-1:0]         src_valid;
  logic [NUM_SRC*FRAME_W-1:0] src_data;
  logic [NUM_SRC-1:0]         src_ready;
  logic [NUM_SRC-1:0]         src_grant;

  modport master (
    output src_req,
    output src_valid,
    output src_data,
    input  src_ready,
    input  src_grant
  );

  modport slave (
    input  src_req,
    input  src_valid,
    input  src_data,
    output src_ready,
    output src_grant
  );

endinterface

// File: rtl/audio_rr_arbiter.sv
// Module: audio_rr_arbiter
// Purpose: combinational round-robin pick. The first requester at or above
//   ptr wins; if none, the lowest requester below ptr wins.
// Ports:
//   req    in  NUM_SRC  request vector
//   ptr    in  PTR_W    highest-priority index this round
//   grant  out NUM_SRC  one-hot winner, 0 when no request
//   winner out PTR_W    index of the winner (0 when no request)
module audio_rr_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_SRC-1:0] grant,
  output logic [PTR_W-1:0]   winner
);

  logic found;

  // Two passes keep every index constant: upper segment first, then wrap.
  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      if (!found && req[s] && (s >= 32'(ptr))) begin
        grant[s] = 1'b1;
        winner   = PTR_W'(s);
        found    = 1'b1;
      end
    end
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      if (!found && req[s]) begin
        grant[s] = 1'b1;
        winner   = PTR_W'(s);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/audio_playback_scheduler.sv
// Module: audio_playback_scheduler
// Purpose: shares the playback serializer among NUM_SRC frame producers.
//   Round-robin grant per stream, one-frame holding buffer, stable 64-bit
//   frame on each serializer read (rising edge of audio_data_rd), word length
//   latched per stream, saturating underrun counter with sticky flag.
// Ports:
//   ac_bclk, ac_reset_n    clock, async active-low reset
//   sched_enable           global enable; low forces IDLE
//   cfg_word_length        word length sampled at stream start
//   src                    producer handshake (audio_playback_scheduler_if.slave)
//   audio_data_rd          serializer read request
//   audio_data_out         frame to serializer
//   word_length            latched word length to serializer
//   underrun_clr           clears counter and flag (wins over a same-cycle underrun)
//   underrun_count/flag    saturating count, sticky flag
//   sched_busy             state != IDLE
// Build option: AUDIO_SCHED_HOLD_LAST_EN -- underrun repeats the previous
//   frame instead of emitting silence.
module audio_playback_scheduler
  import audio_sched_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int CNT_W   = 16
) (
  input  logic                 ac_bclk,
  input  logic                 ac_reset_n,
  input  logic                 sched_enable,
  input  logic [1:0]           cfg_word_length,
  audio_playback_scheduler_if.slave src,
  input  logic                 audio_data_rd,
  output logic [FRAME_W-1:0]   audio_data_out,
  output logic [1:0]           word_length,
  input  logic                 underrun_clr,
  output logic [CNT_W-1:0]     underrun_count,
  output logic                 underrun_flag,
  output logic                 sched_busy
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  sched_state_t       state;
  word_len_t          wl_q;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   winner;
  logic [PTR_W-1:0]   ptr_next;
  logic [NUM_SRC-1:0] pick;
  logic [NUM_SRC-1:0] grant_q;
  logic [FRAME_W-1:0] hold_data;
  logic [FRAME_W-1:0] owner_data;
  logic [FRAME_W-1:0] underrun_frame;
  logic               hold_vld;
  logic               rd_q;
  logic               rd_evt;
  logic               accept;
  logic               owner_req;

  audio_rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req    (src.src_req),
    .ptr    (ptr),
    .grant  (pick),
    .winner (winner)
  );

  assign rd_evt         = audio_data_rd & ~rd_q;
  assign src.src_grant  = grant_q;
  assign src.src_ready  = (state == STREAM && !hold_vld) ? grant_q : '0;
  assign accept         = |(src.src_valid & src.src_ready);
  assign owner_req      = |(src.src_req & grant_q);
  assign word_length    = wl_q;
  assign sched_busy     = (state != IDLE);
  assign ptr_next       = (winner == PTR_W'(NUM_SRC - 1)) ? '0 : winner + 1'b1;

`ifdef AUDIO_SCHED_HOLD_LAST_EN
  assign underrun_frame = audio_data_out;
`else
  assign underrun_frame = '0;
`endif

  always_comb begin
    owner_data = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (grant_q[i]) owner_data = src.src_data[i*FRAME_W +: FRAME_W];
    end
  end

  always_ff @(posedge ac_bclk or negedge ac_reset_n) begin
    if (!ac_reset_n) begin
      state          <= IDLE;
      wl_q           <= WL16;
      ptr            <= '0;
      grant_q        <= '0;
      hold_data      <= '0;
      hold_vld       <= 1'b0;
      rd_q           <= 1'b0;
      audio_data_out <= '0;
      underrun_count <= '0;
      underrun_flag  <= 1'b0;
    end else begin
      rd_q <= audio_data_rd;
      if (!sched_enable) begin
        state    <= IDLE;
        grant_q  <= '0;
        hold_vld <= 1'b0;
        if (rd_evt) audio_data_out <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (rd_evt) audio_data_out <= '0;
            if (|src.src_req) begin
              grant_q <= pick;
              wl_q    <= word_len_t'(cfg_word_length);
              ptr     <= ptr_next;
              state   <= STREAM;
            end
          end
          STREAM: begin
            if (accept) begin
              hold_data <= owner_data;
              hold_vld  <= 1'b1;
            end
            if (rd_evt) begin
              if (hold_vld) begin
                audio_data_out <= hold_data;
                hold_vld       <= 1'b0;
              end else begin
                audio_data_out <= underrun_frame;
                underrun_flag  <= 1'b1;
                if (underrun_count != '1) underrun_count <= underrun_count + 1'b1;
              end
            end
            if (!owner_req) state <= DRAIN;
          end
          DRAIN: begin
            if (!hold_vld) begin
              state   <= IDLE;
              grant_q <= '0;
            end else if (rd_evt) begin
              audio_data_out <= hold_data;
              hold_vld       <= 1'b0;
              state          <= IDLE;
              grant_q        <= '0;
            end
          end
          default: begin
            state    <= IDLE;
            grant_q  <= '0;
            hold_vld <= 1'b0;
          end
        endcase
      end
      // Placed last so a same-cycle clear overrides the underrun update.
      if (underrun_clr) begin
        underrun_count <= '0;
        underrun_flag  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_audio_playback_scheduler.sv
// Testbench: tb_audio_playback_scheduler
// Purpose: directed self-checking bench for audio_playback_scheduler.
//   Counter width is reduced to 4 bits so saturation is reachable quickly.
//   Honours AUDIO_SCHED_HOLD_LAST_EN for the expected underrun frame.
module tb_audio_playback_scheduler;
  import audio_sched_pkg::*;

  localparam int NUM_SRC = 4;
  localparam int CNT_W   = 4;

  localparam logic [63:0] F1 = 64'hAAAA_0001_5555_0001;
  localparam logic [63:0] F2 = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] F3 = 64'hCAFE_0003_BEEF_0003;
  localparam logic [63:0] F4 = 64'h0BAD_F00D_DEAD_0004;
  localparam logic [63:0] F5 = 64'h5555_0005_AAAA_0005;

`ifdef AUDIO_SCHED_HOLD_LAST_EN
  localparam logic [63:0] EXP_UR = F3;
`else
  localparam logic [63:0] EXP_UR = 64'h0;
`endif

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [1:0]       cfg_wl;
  logic             rd;
  logic [63:0]      dout;
  logic [1:0]       wl;
  logic             clr;
  logic [CNT_W-1:0] cnt;
  logic             flag;
  logic             busy;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  audio_playback_scheduler_if #(.NUM_SRC(NUM_SRC)) sif ();

  audio_playback_scheduler #(
    .NUM_SRC (NUM_SRC),
    .CNT_W   (CNT_W)
  ) dut (
    .ac_bclk         (clk),
    .ac_reset_n      (rst_n),
    .sched_enable    (en),
    .cfg_word_length (cfg_wl),
    .src             (sif.slave),
    .audio_data_rd   (rd),
    .audio_data_out  (dout),
    .word_length     (wl),
    .underrun_clr    (clr),
    .underrun_count  (cnt),
    .underrun_flag   (flag),
    .sched_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_pulse();
    rd = 1'b1;
    tick();
    rd = 1'b0;
    tick();
  endtask

  // Present one frame on the producers selected by mask for one cycle.
  task automatic send(input logic [NUM_SRC-1:0] mask, input logic [63:0] f);
    for (int i = 0; i < NUM_SRC; i++) begin
      if (mask[i]) sif.src_data[i*64 +: 64] = f;
    end
    sif.src_valid = mask;
    tick();
    sif.src_valid = '0;
  endtask

  // Owner drops out of a stream; wait DRAIN and IDLE, then the next pick.
  task automatic next_stream(input logic [NUM_SRC-1:0] req);
    sif.src_req = req;
    tick();
    tick();
    tick();
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; cfg_wl = 2'b00; rd = 1'b0; clr = 1'b0;
    sif.src_req = '0; sif.src_valid = '0; sif.src_data = '0;
    tick();
    tick();
    check("rst_grant", 64'(sif.src_grant), 64'h0);
    check("rst_ready", 64'(sif.src_ready), 64'h0);
    check("rst_out", dout, 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_count", 64'(cnt), 64'h0);
    check("rst_wl", 64'(wl), 64'h0);
    rst_n = 1'b1;

    // Single producer, one frame
    en = 1'b1; cfg_wl = 2'b10; sif.src_req = 4'b0001;
    tick();
    check("t1_grant", 64'(sif.src_grant), 64'h1);
    check("t1_busy", 64'(busy), 64'h1);
    check("t1_wl", 64'(wl), 64'h2);
    check("t1_ready", 64'(sif.src_ready), 64'h1);
    send(4'b0001, F1);
    check("t1_ready_full", 64'(sif.src_ready), 64'h0);
    rd_pulse();
    check("t1_out", dout, F1);
    check("t1_count", 64'(cnt), 64'h0);

    // Read request held two cycles counts once
    send(4'b0001, F2);
    rd = 1'b1;
    tick();
    check("t4_out_first", dout, F2);
    tick();
    rd = 1'b0;
    tick();
    check("t4_out_held", dout, F2);
    check("t4_count", 64'(cnt), 64'h0);
    check("t4_flag", 64'(flag), 64'h0);

    // Owner drops with empty buffer: DRAIN then IDLE
    sif.src_req = 4'b0000;
    tick();
    check("drain_busy", 64'(busy), 64'h1);
    check("drain_grant", 64'(sif.src_grant), 64'h1);
    tick();
    check("idle_busy", 64'(busy), 64'h0);
    check("idle_grant", 64'(sif.src_grant), 64'h0);

    // Round robin continues from slot 1; word length latched per stream
    cfg_wl = 2'b00; sif.src_req = 4'b1111;
    tick();
    check("t2_grant_a", 64'(sif.src_grant), 64'h2);
    check("t2_wl_a", 64'(wl), 64'h0);
    cfg_wl = 2'b11;
    tick();
    check("t2_wl_ignored", 64'(wl), 64'h0);
    next_stream(4'b1101);
    check("t2_grant_b", 64'(sif.src_grant), 64'h4);
    check("t2_wl_b", 64'(wl), 64'h3);
    cfg_wl = 2'b01;
    next_stream(4'b1001);
    check("t2_grant_c", 64'(sif.src_grant), 64'h8);
    check("t2_wl_c", 64'(wl), 64'h1);
    next_stream(4'b0001);
    check("t2_grant_wrap", 64'(sif.src_grant), 64'h1);

    // Underruns
    send(4'b0001, F3);
    rd_pulse();
    check("t3_out_frame", dout, F3);
    rd_pulse();
    rd_pulse();
    rd_pulse();
    check("t3_count", 64'(cnt), 64'h3);
    check("t3_flag", 64'(flag), 64'h1);
    check("t3_out", dout, EXP_UR);

    // Clear beats same-cycle underrun
    clr = 1'b1; rd = 1'b1;
    tick();
    check("t5_clr_count", 64'(cnt), 64'h0);
    check("t5_clr_flag", 64'(flag), 64'h0);
    clr = 1'b0; rd = 1'b0;
    tick();

    // Saturation at all-ones
    for (int i = 0; i < 15; i++) rd_pulse();
    check("t5_count_max", 64'(cnt), 64'hF);
    rd_pulse();
    check("t5_count_sat", 64'(cnt), 64'hF);
    check("t5_flag_sat", 64'(flag), 64'h1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("t5_clr_alone", 64'(cnt), 64'h0);

    // Owner drops with a full buffer: flush on next read, then IDLE
    send(4'b0001, F4);
    sif.src_req = 4'b0000;
    tick();
    check("t6_drain_busy", 64'(busy), 64'h1);
    check("t6_drain_grant", 64'(sif.src_grant), 64'h1);
    check("t6_drain_ready", 64'(sif.src_ready), 64'h0);
    tick();
    check("t6_drain_wait", 64'(busy), 64'h1);
    rd = 1'b1;
    tick();
    check("t6_flush_out", dout, F4);
    check("t6_flush_busy", 64'(busy), 64'h0);
    check("t6_flush_grant", 64'(sif.src_grant), 64'h0);
    rd = 1'b0;
    tick();
    check("t6_flush_count", 64'(cnt), 64'h0);

    // Enable low mid-stream
    sif.src_req = 4'b0010;
    tick();
    check("t6_en_grant", 64'(sif.src_grant), 64'h2);
    send(4'b0010, F5);
    en = 1'b0;
    tick();
    check("t6_dis_grant", 64'(sif.src_grant), 64'h0);
    check("t6_dis_busy", 64'(busy), 64'h0);
    check("t6_dis_out", dout, F4);
    rd_pulse();
    check("t6_idle_rd_out", dout, 64'h0);
    en = 1'b1;
    tick();
    check("t6_reen_grant", 64'(sif.src_grant), 64'h2);
    check("t6_reen_ready", 64'(sif.src_ready), 64'h2);
    rd_pulse();
    check("t6_reen_underrun", 64'(cnt), 64'h1);
    check("t6_reen_out", dout, 64'h0);

    // Asynchronous reset mid-stream
    rst_n = 1'b0;
    #1;
    check("arst_grant", 64'(sif.src_grant), 64'h0);
    check("arst_busy", 64'(busy), 64'h0);
    check("arst_count", 64'(cnt), 64'h0);
    check("arst_wl", 64'(wl), 64'h0);
    rst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
